btn_event_ctrl: RTL and testbench

- Front-panel input controller for N_BTN raw push-buttons on the 25 MHz system clock.
- Per button: one existing debounce instance, plus tracking of press, long-press, auto-repeat and release.
- Per-button pending events are arbitrated round-robin into a single valid/ready event stream for the menu/control FSM.
- Sticky overflow flag reports events that were overwritten before being consumed.

---
 rtl/btn_evt_pkg.sv | 19 +
 rtl/btn_debounce.sv | 35 +++
 rtl/btn_tracker.sv | 108 ++++++++++
 rtl/btn_event_ctrl.sv | 103 ++++++++++
 tb/tb_btn_event_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_evt_pkg.sv
// Shared constants and types for the front-panel button event controller.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_LONG    = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;
  localparam logic [1:0] EVT_RELEASE = 2'd3;

  localparam int DEF_LONG_CNT   = 25_000_000;
  localparam int DEF_REPEAT_CNT = 5_000_000;
  localparam int DEF_DB_CNT     = 500_000;

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_HELD,
    TRK_RPT
  } trk_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Debounce for one raw push-button: two-flop synchroniser, then the level must
// stay changed for DB_CNT consecutive cycles before btn_out follows it.
module btn_debounce #(
  parameter int DB_CNT = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_out
);

  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      btn_out <= 1'b0;
    end else begin
      sync <= {sync[0], btn_in};
      if (sync[1] == btn_out) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CNT - 1)) begin
        btn_out <= sync[1];
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_tracker.sv
// Per-button press/long/repeat/release tracker with a single-entry pending slot.
module btn_tracker
  import btn_evt_pkg::*;
#(
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       level,
  input  logic       grant,
  output logic       pend_vld,
  output logic [1:0] pend_type,
  output logic       ovf_set
);

  localparam int TW = $clog2(LONG_CNT);

  trk_state_e    state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          lvl_q;
  logic          rise, fall;
  logic          post;
  logic [1:0]    post_type;

  assign rise = level & ~lvl_q;
  assign fall = ~level & lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TRK_IDLE;
      timer <= '0;
      lvl_q <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      lvl_q <= level;
    end
  end

  // A release seen in the same cycle as a timer expiry wins over the expiry.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    post      = 1'b0;
    post_type = EVT_PRESS;
    case (state)
      TRK_IDLE: begin
        if (rise) begin
          post      = 1'b1;
          post_type = EVT_PRESS;
          state_nx  = TRK_HELD;
          timer_nx  = '0;
        end
      end
      TRK_HELD: begin
        if (fall) begin
          post      = 1'b1;
          post_type = EVT_RELEASE;
          state_nx  = TRK_IDLE;
          timer_nx  = '0;
        end else if (timer == TW'(LONG_CNT - 1)) begin
          post      = 1'b1;
          post_type = EVT_LONG;
          state_nx  = TRK_RPT;
          timer_nx  = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      TRK_RPT: begin
        if (fall) begin
          post      = 1'b1;
          post_type = EVT_RELEASE;
          state_nx  = TRK_IDLE;
          timer_nx  = '0;
        end else if (timer == TW'(REPEAT_CNT - 1)) begin
          post      = 1'b1;
          post_type = EVT_REPEAT;
          timer_nx  = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: begin
        state_nx = TRK_IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // A new post replaces whatever is pending; when granted that same cycle the
  // old entry has already been taken, so only an ungranted replace is a loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_type <= EVT_PRESS;
    end else if (post) begin
      pend_vld  <= 1'b1;
      pend_type <= post_type;
    end else if (grant) begin
      pend_vld <= 1'b0;
    end
  end

  assign ovf_set = post & pend_vld & ~grant;

endmodule

// File: rtl/btn_event_ctrl.sv
// Front-panel controller: debounce and track N_BTN buttons, then merge their
// events round-robin into one valid/ready stream with a sticky overflow flag.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT,
  parameter int DB_CNT     = DEF_DB_CNT,
  parameter int ID_W       = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  logic [N_BTN-1:0] pend_vld;
  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] ovf_set;
  logic [1:0]       pend_type [N_BTN];
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             slot_free;
  logic             any_pend;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CNT (DB_CNT)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_in  (btn_in[g]),
      .btn_out (btn_level[g])
    );

    btn_tracker #(
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT)
    ) u_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .level     (btn_level[g]),
      .grant     (grant_vec[g]),
      .pend_vld  (pend_vld[g]),
      .pend_type (pend_type[g]),
      .ovf_set   (ovf_set[g])
    );
  end

  // Search starts one past the last granted button so every button gets a turn.
  always_comb begin
    grant_vec = '0;
    grant_idx = rr_ptr;
    cand      = '0;
    any_pend  = 1'b0;
    slot_free = !evt_valid || evt_ready;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_BTN);
      if (!any_pend && pend_vld[cand]) begin
        any_pend  = 1'b1;
        grant_idx = cand;
      end
    end
    if (slot_free && any_pend) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= EVT_PRESS;
      rr_ptr    <= ID_W'(N_BTN - 1);
      evt_ovf   <= 1'b0;
    end else begin
      if (slot_free) begin
        if (any_pend) begin
          evt_valid <= 1'b1;
          evt_id    <= grant_idx;
          evt_type  <= pend_type[grant_idx];
          rr_ptr    <= grant_idx;
        end else begin
          evt_valid <= 1'b0;
        end
      end
      if (|ovf_set) begin
        evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl: stimulus pushes expected events, a
// negedge monitor pops and compares on every accepted handshake.
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

  localparam int N_BTN      = 4;
  localparam int LONG_CNT   = 1000;
  localparam int REPEAT_CNT = 200;
  localparam int DB_CNT     = 8;
  localparam int ID_W       = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N_BTN-1:0] btn_in = '0;
  logic [N_BTN-1:0] btn_level;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic [ID_W-1:0]  evt_id;
  logic [1:0]       evt_type;
  logic             evt_ovf;
  logic             ovf_clr = 1'b0;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] typ;
  } evt_t;

  evt_t sb[$];
  int   hs_log[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  btn_event_ctrl #(
    .N_BTN      (N_BTN),
    .LONG_CNT   (LONG_CNT),
    .REPEAT_CNT (REPEAT_CNT),
    .DB_CNT     (DB_CNT),
    .ID_W       (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_type  (evt_type),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic evt_t mk(input int id, input logic [1:0] typ);
    evt_t e;
    e.id  = 2'(id);
    e.typ = typ;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Every accepted event must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      hs_log.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_evt: got id %0d type %0d, expected no event", evt_id, evt_type);
      end else begin
        evt_t exp_e;
        exp_e = sb.pop_front();
        check_output("evt_id", 32'(evt_id), 32'(exp_e.id));
        check_output("evt_type", 32'(evt_type), 32'(exp_e.typ));
      end
    end
  end

  task automatic apply_stimulus(input logic [N_BTN-1:0] value);
    @(posedge clk);
    #5 btn_in = value;
  endtask

  task automatic set_ready(input logic value);
    @(posedge clk);
    #5 evt_ready = value;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input int idx, input logic value, input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (btn_level[idx] === value) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) report_timeout($sformatf("level%0d_to_%0d", idx, value));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (done == 0) report_timeout(name);
  endtask

  task automatic check_gap(input string name, input int i, input int expected);
    if (hs_log.size() > i) check_output(name, 32'(hs_log[i] - hs_log[i-1]), 32'(expected));
    else report_timeout(name);
  endtask

  initial begin
    #(40 * 40000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t_lvl;
    int seen_valid;

    #5 rst_n = 1'b0;
    idle(3);
    check_output("rst_evt_valid", 32'(evt_valid), 0);
    check_output("rst_evt_id", 32'(evt_id), 0);
    check_output("rst_evt_type", 32'(evt_type), 0);
    check_output("rst_evt_ovf", 32'(evt_ovf), 0);
    check_output("rst_btn_level", 32'(btn_level), 0);
    rst_n = 1'b1;
    idle(3);

    // Short press on button 1: PRESS and RELEASE two cycles after each level edge.
    sb.push_back(mk(1, EVT_PRESS));
    apply_stimulus(4'b0010);
    wait_level(1, 1'b1, 100, t_lvl);
    wait_drain("press1_drain", 50);
    check_output("press1_latency", 32'(hs_log[$] - t_lvl), 2);
    idle(100);
    sb.push_back(mk(1, EVT_RELEASE));
    apply_stimulus(4'b0000);
    wait_level(1, 1'b0, 100, t_lvl);
    wait_drain("release1_drain", 50);
    check_output("release1_latency", 32'(hs_log[$] - t_lvl), 2);

    // Long hold on button 0: LONG after 1000 cycles, then REPEAT every 200.
    hs_log.delete();
    sb.push_back(mk(0, EVT_PRESS));
    sb.push_back(mk(0, EVT_LONG));
    sb.push_back(mk(0, EVT_REPEAT));
    sb.push_back(mk(0, EVT_REPEAT));
    apply_stimulus(4'b0001);
    wait_drain("long0_drain", 3000);
    sb.push_back(mk(0, EVT_RELEASE));
    apply_stimulus(4'b0000);
    wait_drain("long0_release", 100);
    check_gap("long_gap", 1, LONG_CNT);
    check_gap("repeat1_gap", 2, REPEAT_CNT);
    check_gap("repeat2_gap", 3, REPEAT_CNT);

    // Buttons 0 and 2 together with rr_ptr=0: search 1,2,... so id2 first, back-to-back.
    hs_log.delete();
    sb.push_back(mk(2, EVT_PRESS));
    sb.push_back(mk(0, EVT_PRESS));
    apply_stimulus(4'b0101);
    wait_drain("pair_press_a", 100);
    check_gap("pair_press_b2b", 1, 1);
    hs_log.delete();
    sb.push_back(mk(2, EVT_RELEASE));
    sb.push_back(mk(0, EVT_RELEASE));
    apply_stimulus(4'b0000);
    wait_drain("pair_release_a", 100);
    check_gap("pair_release_b2b", 1, 1);

    // Consumer stalled: PRESS2 held in output, PRESS3 overwritten by RELEASE3.
    set_ready(1'b0);
    sb.push_back(mk(2, EVT_PRESS));
    sb.push_back(mk(3, EVT_RELEASE));
    sb.push_back(mk(2, EVT_RELEASE));
    apply_stimulus(4'b0100);
    wait_level(2, 1'b1, 100, t_lvl);
    idle(3);
    check_output("stall_valid", 32'(evt_valid), 1);
    check_output("stall_id", 32'(evt_id), 2);
    check_output("stall_type", 32'(evt_type), 32'(EVT_PRESS));
    apply_stimulus(4'b1100);
    wait_level(3, 1'b1, 100, t_lvl);
    idle(3);
    check_output("ovf_before_overwrite", 32'(evt_ovf), 0);
    apply_stimulus(4'b0100);
    wait_level(3, 1'b0, 100, t_lvl);
    idle(3);
    check_output("ovf_after_overwrite", 32'(evt_ovf), 1);
    apply_stimulus(4'b0000);
    wait_level(2, 1'b0, 100, t_lvl);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_output("hold_valid", 32'(evt_valid), 1);
      check_output("hold_id", 32'(evt_id), 2);
      check_output("hold_type", 32'(evt_type), 32'(EVT_PRESS));
    end
    set_ready(1'b1);
    wait_drain("stall_drain", 100);
    check_output("ovf_sticky", 32'(evt_ovf), 1);
    @(posedge clk);
    #5 ovf_clr = 1'b1;
    @(posedge clk);
    #5 ovf_clr = 1'b0;
    @(negedge clk);
    check_output("ovf_cleared", 32'(evt_ovf), 0);

    // Same pair again, now rr_ptr=2: search 3,0,... so id0 first.
    sb.push_back(mk(0, EVT_PRESS));
    sb.push_back(mk(2, EVT_PRESS));
    apply_stimulus(4'b0101);
    wait_drain("pair_press_b", 100);
    sb.push_back(mk(0, EVT_RELEASE));
    sb.push_back(mk(2, EVT_RELEASE));
    apply_stimulus(4'b0000);
    wait_drain("pair_release_b", 100);

    // Reset in the middle of auto-repeat with an event held and one pending.
    sb.push_back(mk(0, EVT_PRESS));
    sb.push_back(mk(0, EVT_LONG));
    apply_stimulus(4'b0001);
    wait_drain("rpt_setup", 2000);
    set_ready(1'b0);
    idle(650);
    check_output("pre_rst_valid", 32'(evt_valid), 1);
    check_output("pre_rst_type", 32'(evt_type), 32'(EVT_REPEAT));
    check_output("pre_rst_ovf", 32'(evt_ovf), 1);
    @(negedge clk);
    #7;
    rst_n = 1'b0;
    btn_in = '0;
    #1;
    check_output("async_rst_valid", 32'(evt_valid), 0);
    check_output("async_rst_ovf", 32'(evt_ovf), 0);
    check_output("async_rst_level", 32'(btn_level), 0);
    idle(3);
    rst_n = 1'b1;
    set_ready(1'b1);
    seen_valid = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (evt_valid) seen_valid = 1;
    end
    check_output("quiet_after_reset", 32'(seen_valid), 0);
    sb.push_back(mk(0, EVT_PRESS));
    sb.push_back(mk(0, EVT_RELEASE));
    apply_stimulus(4'b0001);
    wait_level(0, 1'b1, 100, t_lvl);
    idle(20);
    apply_stimulus(4'b0000);
    wait_drain("post_rst_drain", 100);

    idle(20);
    check_output("sb_leftover", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
